// File: rtl/mc_control_fsm_pkg.sv
// Shared types, opcodes and control encodings for the multicycle controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, IMMEX, IMMWB, JEX, JALEX, EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  } aluop_t;

  typedef enum logic [2:0] {
    SRCB_B, SRCB_FOUR, SRCB_SIMM, SRCB_SIMM_SH2, SRCB_ZIMM
  } alusrcb_t;

  typedef enum logic [1:0] {PC_ALURES, PC_ALUOUT, PC_JUMP, PC_EXCVEC} pcsrc_t;
  typedef enum logic [1:0] {WB_ALUOUT, WB_LOAD, WB_PC} wb_sel_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_R31} regdst_t;
  typedef enum logic [2:0] {LD_WORD, LD_BU, LD_B, LD_HU, LD_H} load_mode_t;
  typedef enum logic [1:0] {ST_WORD, ST_BYTE, ST_HALF} store_mode_t;
  typedef enum logic [1:0] {EXC_NONE, EXC_ILLEGAL, EXC_BUS_TIMEOUT} exc_code_t;

  // Per-state control word; fetch_en/wr_en are qualified by mem_ready at the port.
  typedef struct packed {
    logic        mem_req;
    logic        iord;
    logic        alusrca;
    logic        regwrite;
    logic        pcwrite;
    logic        branch;
    logic        bne;
    logic        epcwrite;
    logic        exc_valid;
    logic        fetch_en;
    logic        wr_en;
    alusrcb_t    alusrcb;
    aluop_t      aluop;
    pcsrc_t      pcsrc;
    wb_sel_t     memtoreg;
    regdst_t     regdst;
    load_mode_t  load_mode;
    store_mode_t store_mode;
  } ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic load_mode_t load_mode_of(input logic [5:0] op);
    case (op)
      OP_LBU:  return LD_BU;
      OP_LB:   return LD_B;
      OP_LHU:  return LD_HU;
      OP_LH:   return LD_H;
      default: return LD_WORD;
    endcase
  endfunction

  function automatic store_mode_t store_mode_of(input logic [5:0] op);
    case (op)
      OP_SB:   return ST_BYTE;
      OP_SH:   return ST_HALF;
      default: return ST_WORD;
    endcase
  endfunction

  // Moore decode of the control word for a state; unlisted fields stay zero.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req  = 1'b1;
        c.fetch_en = 1'b1;
        c.alusrcb  = SRCB_FOUR;
      end
      DECODE:  c.alusrcb = SRCB_SIMM_SH2;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_SIMM;
      end
      MEMRD: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.load_mode = load_mode_of(op);
      end
      MEMWB: begin
        c.regwrite  = 1'b1;
        c.memtoreg  = WB_LOAD;
        c.load_mode = load_mode_of(op);
      end
      MEMWR: begin
        c.mem_req    = 1'b1;
        c.iord       = 1'b1;
        c.wr_en      = 1'b1;
        c.store_mode = store_mode_of(op);
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FUNCT;
      end
      RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = DST_RD;
      end
      BEQEX, BNEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = (s == BEQEX);
        c.bne     = (s == BNEEX);
      end
      IMMEX: begin
        c.alusrca = 1'b1;
        case (op)
          OP_ADDI: begin c.alusrcb = SRCB_SIMM; c.aluop = ALU_ADD; end
          OP_SLTI: begin c.alusrcb = SRCB_SIMM; c.aluop = ALU_SLT; end
          OP_ANDI: begin c.alusrcb = SRCB_ZIMM; c.aluop = ALU_AND; end
          OP_ORI:  begin c.alusrcb = SRCB_ZIMM; c.aluop = ALU_OR;  end
          OP_XORI: begin c.alusrcb = SRCB_ZIMM; c.aluop = ALU_XOR; end
          default: c.alusrcb = SRCB_B;
        endcase
      end
      IMMWB:   c.regwrite = 1'b1;
      JEX: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = PC_JUMP;
      end
      JALEX: begin
        c.pcwrite  = 1'b1;
        c.pcsrc    = PC_JUMP;
        c.regwrite = 1'b1;
        c.regdst   = DST_R31;
        c.memtoreg = WB_PC;
      end
      EXC: begin
        c.exc_valid = 1'b1;
        c.epcwrite  = 1'b1;
        c.pcwrite   = 1'b1;
        c.pcsrc     = PC_EXCVEC;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle.
interface mc_control_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       branch;
  logic       bne;
  logic       iord;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic [2:0] load_mode;
  logic [1:0] store_mode;
  logic       epcwrite;
  logic       exc_valid;
  logic [1:0] exc_code;

  modport master (
    input  op, mem_ready,
    output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           bne, iord, memtoreg, regdst, alusrcb, pcsrc, aluop, load_mode,
           store_mode, epcwrite, exc_valid, exc_code
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           bne, iord, memtoreg, regdst, alusrcb, pcsrc, aluop, load_mode,
           store_mode, epcwrite, exc_valid, exc_code
  );
endinterface

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory wait counter with timeout compare; TIMEOUT of 0 never expires.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // Count stalled wait cycles; any state change restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with memory wait timeout and exceptions.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);

  state_t    state, state_n;
  ctrl_t     ctrl_q;
  exc_code_t exc_code_q, exc_code_n;
  logic      waiting;
  logic      expired;
  logic      live;

  assign waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  mc_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_n != state),
    .inc    (waiting && !bus.mem_ready),
    .expired(expired)
  );

  // Next-state selection; mem_ready is tested before the timeout so it wins.
  always_comb begin
    state_n    = state;
    exc_code_n = EXC_NONE;
    case (state)
      FETCH: begin
        if (bus.mem_ready) state_n = DECODE;
        else if (expired) begin
          state_n    = EXC;
          exc_code_n = EXC_BUS_TIMEOUT;
        end
      end
      DECODE: begin
        if (is_load(bus.op) || is_store(bus.op)) state_n = MEMADR;
        else begin
          case (bus.op)
            OP_RTYPE: state_n = RTYPEEX;
            OP_BEQ:   state_n = BEQEX;
            OP_BNE:   state_n = BNEEX;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_n = IMMEX;
            OP_J:     state_n = JEX;
            OP_JAL:   state_n = JALEX;
            default: begin
              state_n    = EXC;
              exc_code_n = EXC_ILLEGAL;
            end
          endcase
        end
      end
      MEMADR:  state_n = is_load(bus.op) ? MEMRD : MEMWR;
      MEMRD: begin
        if (bus.mem_ready) state_n = MEMWB;
        else if (expired) begin
          state_n    = EXC;
          exc_code_n = EXC_BUS_TIMEOUT;
        end
      end
      MEMWR: begin
        if (bus.mem_ready) state_n = FETCH;
        else if (expired) begin
          state_n    = EXC;
          exc_code_n = EXC_BUS_TIMEOUT;
        end
      end
      RTYPEEX: state_n = RTYPEWB;
      IMMEX:   state_n = IMMWB;
      MEMWB, RTYPEWB, BEQEX, BNEEX, IMMWB, JEX, JALEX, EXC: state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  // State, control word and exception code registered together on each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      ctrl_q     <= ctrl_decode(FETCH, 6'b000000);
      exc_code_q <= EXC_NONE;
    end else begin
      state      <= state_n;
      ctrl_q     <= ctrl_decode(state_n, bus.op);
      exc_code_q <= exc_code_n;
    end
  end

  // The control word is registered, but irwrite/pcwrite/memwrite must fire in
  // the very cycle memory completes, so those keep a final AND with mem_ready.
  // The word resets to FETCH values so the first cycle after release requests;
  // strobes and mem_req are masked while reset is held.
  assign live = !reset;

  assign bus.mem_req    = ctrl_q.mem_req & live;
  assign bus.irwrite    = ctrl_q.fetch_en & bus.mem_ready & live;
  assign bus.pcwrite    = (ctrl_q.pcwrite | (ctrl_q.fetch_en & bus.mem_ready)) & live;
  assign bus.memwrite   = ctrl_q.wr_en & bus.mem_ready & live;
  assign bus.regwrite   = ctrl_q.regwrite & live;
  assign bus.branch     = ctrl_q.branch & live;
  assign bus.bne        = ctrl_q.bne & live;
  assign bus.epcwrite   = ctrl_q.epcwrite & live;
  assign bus.exc_valid  = ctrl_q.exc_valid & live;
  assign bus.iord       = ctrl_q.iord;
  assign bus.alusrca    = ctrl_q.alusrca;
  assign bus.alusrcb    = ctrl_q.alusrcb;
  assign bus.aluop      = ctrl_q.aluop;
  assign bus.pcsrc      = ctrl_q.pcsrc;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.regdst     = ctrl_q.regdst;
  assign bus.load_mode  = ctrl_q.load_mode;
  assign bus.store_mode = ctrl_q.store_mode;
  assign bus.exc_code   = exc_code_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm (TIMEOUT=4).
module tb_mc_control_fsm;

  typedef enum int {
    P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_RX, P_RWB,
    P_BEQ, P_BNE, P_IX, P_IWB, P_J, P_JAL, P_EXC
  } phase_t;

  typedef struct {
    string       tag;
    logic [29:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t scb[$];

  mc_control_fsm_if bus();

  mc_control_fsm #(
    .TIMEOUT(4),
    .TO_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [29:0] act;
  assign act = {bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite, bus.memwrite,
                bus.regwrite, bus.alusrca, bus.branch, bus.bne, bus.epcwrite,
                bus.exc_valid, bus.alusrcb, bus.aluop, bus.pcsrc, bus.memtoreg,
                bus.regdst, bus.load_mode, bus.store_mode, bus.exc_code};

  task automatic check_eq(input string tag, input logic [29:0] got, input logic [29:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [2:0] lm_of(input logic [5:0] o);
    case (o)
      6'b100100: return 3'b001;
      6'b100000: return 3'b010;
      6'b100101: return 3'b011;
      6'b100001: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] sm_of(input logic [5:0] o);
    case (o)
      6'b101000: return 2'b01;
      6'b101001: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

  // Reference outputs for one cycle, taken from the state output tables.
  function automatic logic [29:0] ev(input phase_t ph, input logic [5:0] o,
                                     input logic rdy, input logic [1:0] code);
    logic mreq, iord, irw, pcw, mw, rw, srca, br, bn, epc, exv;
    logic [2:0] srcb, aop, lm;
    logic [1:0] pcs, m2r, rdst, sm, ec;
    {mreq, iord, irw, pcw, mw, rw, srca, br, bn, epc, exv} = '0;
    {srcb, aop, lm, pcs, m2r, rdst, sm, ec} = '0;
    case (ph)
      P_RST:  srcb = 3'b001;
      P_F:    begin mreq = 1; srcb = 3'b001; irw = rdy; pcw = rdy; end
      P_D:    srcb = 3'b011;
      P_MA:   begin srca = 1; srcb = 3'b010; end
      P_MR:   begin mreq = 1; iord = 1; lm = lm_of(o); end
      P_MWB:  begin rw = 1; m2r = 2'b01; lm = lm_of(o); end
      P_MW:   begin mreq = 1; iord = 1; sm = sm_of(o); mw = rdy; end
      P_RX:   begin srca = 1; aop = 3'b010; end
      P_RWB:  begin rw = 1; rdst = 2'b01; end
      P_BEQ:  begin srca = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
      P_BNE:  begin srca = 1; aop = 3'b001; pcs = 2'b01; bn = 1; end
      P_IX: begin
        srca = 1;
        case (o)
          6'b001000: begin srcb = 3'b010; aop = 3'b000; end
          6'b001010: begin srcb = 3'b010; aop = 3'b110; end
          6'b001100: begin srcb = 3'b100; aop = 3'b011; end
          6'b001101: begin srcb = 3'b100; aop = 3'b100; end
          default:   begin srcb = 3'b100; aop = 3'b101; end
        endcase
      end
      P_IWB:  rw = 1;
      P_J:    begin pcw = 1; pcs = 2'b10; end
      P_JAL:  begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
      P_EXC:  begin exv = 1; epc = 1; pcw = 1; pcs = 2'b11; ec = code; end
      default: ;
    endcase
    return {mreq, iord, irw, pcw, mw, rw, srca, br, bn, epc, exv,
            srcb, aop, pcs, m2r, rdst, lm, sm, ec};
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show in it.
  task automatic step(input string tag, input phase_t ph, input logic rdy,
                      input logic [1:0] code = 2'b00);
    exp_t e;
    bus.mem_ready = rdy;
    e.tag = tag;
    e.v   = ev(ph, bus.op, rdy, code);
    scb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle and compare against the oldest queued expectation.
  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      check_eq(e.tag, act, e.v);
    end
  end

  // One full instruction with zero-wait fetch and `waits` stalls on data access.
  task automatic run_op(input string tag, input logic [5:0] o, input int unsigned waits);
    bus.op = o;
    step({tag, "/F"}, P_F, 1'b1);
    step({tag, "/D"}, P_D, 1'b0);
    if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      step({tag, "/MA"}, P_MA, 1'b0);
      for (int unsigned i = 0; i < waits; i++) step({tag, "/MRw"}, P_MR, 1'b0);
      step({tag, "/MR"}, P_MR, 1'b1);
      step({tag, "/MWB"}, P_MWB, 1'b0);
    end else if (o inside {6'h28, 6'h29, 6'h2B}) begin
      step({tag, "/MA"}, P_MA, 1'b0);
      for (int unsigned i = 0; i < waits; i++) step({tag, "/MWw"}, P_MW, 1'b0);
      step({tag, "/MW"}, P_MW, 1'b1);
    end else begin
      case (o)
        6'h00: begin step({tag, "/RX"}, P_RX, 1'b0); step({tag, "/RWB"}, P_RWB, 1'b0); end
        6'h04: step({tag, "/BEQ"}, P_BEQ, 1'b0);
        6'h05: step({tag, "/BNE"}, P_BNE, 1'b0);
        6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
          step({tag, "/IX"}, P_IX, 1'b0);
          step({tag, "/IWB"}, P_IWB, 1'b0);
        end
        6'h02: step({tag, "/J"}, P_J, 1'b0);
        6'h03: step({tag, "/JAL"}, P_JAL, 1'b0);
        default: step({tag, "/EXC"}, P_EXC, 1'b0, 2'b01);
      endcase
    end
  endtask

  logic [5:0] ops [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                           6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h21, 6'h23, 6'h24,
                           6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h10};

  initial begin
    reset = 1'b1;
    bus.op = 6'h00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("rst0", P_RST, 1'b0);
    step("rst1", P_RST, 1'b1);
    reset = 1'b0;

    // LW with three stalls in MEMRD, then JAL and an illegal opcode.
    run_op("lw3", 6'h23, 3);
    run_op("jal", 6'h03, 0);
    run_op("ill", 6'h3F, 0);

    // Every opcode class, with varying data-access stalls.
    for (int i = 0; i < 20; i++)
      run_op($sformatf("op%02h", ops[i]), ops[i], i % 3);

    // Fetch stalls until timeout: four FETCH cycles, then bus-timeout exception.
    bus.op = 6'h23;
    for (int i = 0; i < 4; i++) step("tof/F", P_F, 1'b0);
    step("tof/EXC", P_EXC, 1'b0, 2'b10);

    // Ready arrives on the last allowed wait cycle: normal completion.
    bus.op = 6'h08;
    for (int i = 0; i < 3; i++) step("edge/Fw", P_F, 1'b0);
    step("edge/F", P_F, 1'b1);
    step("edge/D", P_D, 1'b0);
    step("edge/IX", P_IX, 1'b0);
    step("edge/IWB", P_IWB, 1'b0);

    // Timeout on the data read and on the data write.
    run_op("aft", 6'h00, 0);
    bus.op = 6'h21;
    step("tor/F", P_F, 1'b1);
    step("tor/D", P_D, 1'b0);
    step("tor/MA", P_MA, 1'b0);
    for (int i = 0; i < 4; i++) step("tor/MR", P_MR, 1'b0);
    step("tor/EXC", P_EXC, 1'b0, 2'b10);
    bus.op = 6'h29;
    step("tow/F", P_F, 1'b1);
    step("tow/D", P_D, 1'b0);
    step("tow/MA", P_MA, 1'b0);
    for (int i = 0; i < 4; i++) step("tow/MW", P_MW, 1'b0);
    step("tow/EXC", P_EXC, 1'b0, 2'b10);

    // Reset in the middle of a store wait abandons the write.
    bus.op = 6'h2B;
    step("rsw/F", P_F, 1'b1);
    step("rsw/D", P_D, 1'b0);
    step("rsw/MA", P_MA, 1'b0);
    step("rsw/MW", P_MW, 1'b0);
    step("rsw/MW", P_MW, 1'b0);
    reset = 1'b1;
    step("rsw/R", P_RST, 1'b1);
    step("rsw/R", P_RST, 1'b0);
    reset = 1'b0;
    step("rsw/F0", P_F, 1'b0);
    run_op("rsw/sw", 6'h2B, 1);
    run_op("last", 6'h05, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
